// File: rtl/lzc_normalizer.sv
// Leading-zero normalizer: one-hot of the leading one, binary count, left shift to set the MSB.
// Latency: 3 cycles, accept to output, with out_ready held high; one word per cycle.
// Backpressure: each stage advances on its own, bubbles compress, and in_ready is combinational from out_ready.
module lzc_normalizer #(
  parameter  int WIDTH   = 16,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(WIDTH - 1);

  // Stage 1 registers
  logic               s1_vld;
  logic [WIDTH-1:0]   s1_data;
  logic [WIDTH-1:0]   s1_lead_oh;
  logic               s1_zero;

  // Stage 2 registers
  logic               s2_vld;
  logic [WIDTH-1:0]   s2_data;
  logic [SHIFT_W-1:0] s2_shift;
  logic               s2_zero;

  // Stage 3 registers, which drive the outputs directly
  logic               s3_vld;
  logic [WIDTH-1:0]   s3_data;
  logic [SHIFT_W-1:0] s3_shift;
  logic               s3_zero;

  // Per-stage load enables
  logic ld1, ld2, ld3;

  // Combinational helpers
  logic [WIDTH-1:0]   lead_oh;
  logic               seen;
  logic [SHIFT_W-1:0] idx;
  logic [SHIFT_W-1:0] shift_next;

  // A stage loads when it is empty or when the stage after it is taking its word.
  always_comb begin
    ld3      = ~s3_vld | out_ready;
    ld2      = ~s2_vld | ld3;
    ld1      = ~s1_vld | ld2;
    in_ready = ld1;
  end

  // Isolate the highest set bit: scan from the MSB and mask every bit below the first one.
  always_comb begin
    seen    = 1'b0;
    lead_oh = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      lead_oh[i] = in_data[i] & ~seen;
      seen       = seen | in_data[i];
    end
  end

  // One-hot to binary: bit k of the index ORs every one-hot position whose index has bit k set.
  always_comb begin
    idx = '0;
    for (int k = 0; k < SHIFT_W; k++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (((j >> k) & 1) == 1) begin
          idx[k] = idx[k] | s1_lead_oh[j];
        end
      end
    end
    // An all-zero word has no leading one, so its shift is pinned to 0.
    shift_next = s1_zero ? '0 : (MAX_SHIFT - idx);
  end

  // Stage 1: capture the word, its leading-one vector and the zero flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_lead_oh <= '0;
      s1_zero    <= 1'b0;
    end else if (ld1) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_data    <= in_data;
        s1_lead_oh <= lead_oh;
        s1_zero    <= ~|in_data;
      end
    end
  end

  // Stage 2: capture the leading-zero count alongside the word.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_vld   <= 1'b0;
      s2_data  <= '0;
      s2_shift <= '0;
      s2_zero  <= 1'b0;
    end else if (ld2) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data  <= s1_data;
        s2_shift <= shift_next;
        s2_zero  <= s1_zero;
      end
    end
  end

  // Stage 3: capture the normalized word; only zeros are shifted out, so nothing is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      s3_vld   <= 1'b0;
      s3_data  <= '0;
      s3_shift <= '0;
      s3_zero  <= 1'b0;
    end else if (ld3) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_data  <= s2_data << s2_shift;
        s3_shift <= s2_shift;
        s3_zero  <= s2_zero;
      end
    end
  end

  assign out_valid = s3_vld;
  assign out_data  = s3_data;
  assign out_shift = s3_shift;
  assign out_zero  = s3_zero;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer: a WIDTH=16 instance and a WIDTH=5 instance.
// Directed vectors check exact latency; a negedge scoreboard checks every output against a counting model.
// Covers streaming, a full-pipeline stall, reset while words are in flight, and random backpressure.
module tb_lzc_normalizer;

  typedef struct {
    logic [15:0] data;
    int          shift;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] in;
    logic [15:0] data;
    int          shift;
    logic        zero;
  } vec_t;

  logic        clock;
  logic        reset;

  logic [15:0] in_data16;
  logic        in_valid16, in_ready16;
  logic [15:0] out_data16;
  logic [3:0]  out_shift16;
  logic        out_zero16, out_valid16, out_ready16;

  logic [4:0]  in_data5;
  logic        in_valid5, in_ready5;
  logic [4:0]  out_data5;
  logic [2:0]  out_shift5;
  logic        out_zero5, out_valid5, out_ready5;

  int checks = 0;
  int errors = 0;
  int n_out16 = 0;
  int n_out5 = 0;

  exp_t q16[$];
  exp_t q5[$];

  lzc_normalizer #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset),
    .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_shift(out_shift16), .out_zero(out_zero16),
    .out_valid(out_valid16), .out_ready(out_ready16)
  );

  lzc_normalizer #(.WIDTH(5)) dut5 (
    .clock(clock), .reset(reset),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_shift(out_shift5), .out_zero(out_zero5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count zeros down from the MSB, then shift and mask to w bits.
  function automatic exp_t model(input logic [15:0] x, input int w);
    exp_t e;
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
    e.zero  = ((x & mask) == 16'h0);
    e.shift = 0;
    if (!e.zero) begin
      while (x[w-1-e.shift] == 1'b0) e.shift++;
    end
    e.data = (x << e.shift) & mask;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard for both instances, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (out_valid16) begin
        if (q16.size() == 0) begin
          if (out_ready16) begin
            checks++; errors++;
            $display("FAIL w16_unexpected_output actual=0x%0h expected=none", out_data16);
          end
        end else begin
          e = q16[0];
          cmp("w16_out_data", {16'h0, out_data16}, {16'h0, e.data});
          cmp("w16_out_shift", {28'h0, out_shift16}, e.shift);
          cmp("w16_out_zero", {31'h0, out_zero16}, {31'h0, e.zero});
          if (out_ready16) begin
            void'(q16.pop_front());
            n_out16++;
          end
        end
      end
      if (in_valid16 && in_ready16) q16.push_back(model(in_data16, 16));

      if (out_valid5) begin
        if (q5.size() == 0) begin
          if (out_ready5) begin
            checks++; errors++;
            $display("FAIL w5_unexpected_output actual=0x%0h expected=none", out_data5);
          end
        end else begin
          e = q5[0];
          cmp("w5_out_data", {27'h0, out_data5}, {16'h0, e.data});
          cmp("w5_out_shift", {29'h0, out_shift5}, e.shift);
          cmp("w5_out_zero", {31'h0, out_zero5}, {31'h0, e.zero});
          if (out_ready5) begin
            void'(q5.pop_front());
            n_out5++;
          end
        end
      end
      if (in_valid5 && in_ready5) q5.push_back(model({11'h0, in_data5}, 5));
    end
  end

  task automatic drain16();
    int b;
    b = 0;
    while (q16.size() != 0 && b < 50) begin
      step();
      b++;
    end
    cmp("w16_drained", q16.size(), 0);
  endtask

  task automatic drain5();
    int b;
    b = 0;
    while (q5.size() != 0 && b < 200) begin
      step();
      b++;
    end
    cmp("w5_drained", q5.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int acc, gaps, drops, n0;
    logic ok;

    vecs[0] = '{in: 16'h0001, data: 16'h8000, shift: 15, zero: 1'b0};
    vecs[1] = '{in: 16'h8000, data: 16'h8000, shift: 0,  zero: 1'b0};
    vecs[2] = '{in: 16'h00F0, data: 16'hF000, shift: 8,  zero: 1'b0};
    vecs[3] = '{in: 16'h0000, data: 16'h0000, shift: 0,  zero: 1'b1};
    vecs[4] = '{in: 16'h1234, data: 16'h91A0, shift: 3,  zero: 1'b0};

    reset = 1'b1;
    in_data16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1;
    in_data5 = '0;  in_valid5 = 1'b0;  out_ready5 = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    cmp("reset_out_valid", {31'h0, out_valid16}, 0);
    cmp("reset_out_data", {16'h0, out_data16}, 0);
    cmp("reset_out_shift", {28'h0, out_shift16}, 0);
    cmp("reset_out_zero", {31'h0, out_zero16}, 0);
    cmp("reset_in_ready", {31'h0, in_ready16}, 1);
    cmp("reset_w5_out_valid", {31'h0, out_valid5}, 0);

    // Directed vectors with exact three-cycle latency.
    for (int i = 0; i < 5; i++) begin
      in_valid16 = 1'b1;
      in_data16  = vecs[i].in;
      #1;
      cmp("vec_in_ready", {31'h0, in_ready16}, 1);
      step();
      in_valid16 = 1'b0;
      in_data16  = 16'hDEAD;
      step();
      cmp("vec_not_early", {31'h0, out_valid16}, 0);
      step();
      cmp("vec_out_valid", {31'h0, out_valid16}, 1);
      cmp("vec_out_data", {16'h0, out_data16}, {16'h0, vecs[i].data});
      cmp("vec_out_shift", {28'h0, out_shift16}, vecs[i].shift);
      cmp("vec_out_zero", {31'h0, out_zero16}, {31'h0, vecs[i].zero});
      step();
    end
    drain16();

    // Streaming: back-to-back words, no stalls expected.
    gaps = 0; drops = 0; n0 = n_out16;
    for (int i = 0; i < 1000; i++) begin
      in_valid16 = 1'b1;
      in_data16  = 16'($urandom) >> $urandom_range(0, 15);
      #1;
      if (!in_ready16) drops++;
      step();
      if (i >= 2 && !out_valid16) gaps++;
    end
    in_valid16 = 1'b0;
    drain16();
    cmp("stream_in_ready_drops", drops, 0);
    cmp("stream_output_gaps", gaps, 0);
    cmp("stream_output_count", n_out16 - n0, 1000);

    // Backpressure: stall for six cycles with input always offered.
    out_ready16 = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid16 = 1'b1;
      in_data16  = 16'($urandom) >> $urandom_range(0, 15);
      #1;
      if (in_ready16) acc++;
      if (c >= 3) cmp("stall_in_ready_low", {31'h0, in_ready16}, 0);
      step();
    end
    cmp("stall_accepted", acc, 3);
    cmp("stall_out_valid", {31'h0, out_valid16}, 1);
    out_ready16 = 1'b1;
    in_data16   = 16'h0040;
    #1;
    cmp("release_in_ready", {31'h0, in_ready16}, 1);
    step();
    in_valid16 = 1'b0;
    drain16();

    // Reset with three words in flight.
    out_ready16 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid16 = 1'b1;
      in_data16  = 16'h0100 << c;
      step();
    end
    in_valid16 = 1'b0;
    reset = 1'b1;
    q16.delete();
    step();
    reset = 1'b0;
    #1;
    cmp("midreset_out_valid", {31'h0, out_valid16}, 0);
    cmp("midreset_in_ready", {31'h0, in_ready16}, 1);
    cmp("midreset_out_data", {16'h0, out_data16}, 0);
    out_ready16 = 1'b1;
    for (int c = 0; c < 5; c++) step();
    cmp("midreset_no_stale", {31'h0, out_valid16}, 0);
    in_valid16 = 1'b1;
    in_data16  = 16'h0003;
    step();
    in_valid16 = 1'b0;
    drain16();

    // WIDTH=5: exhaustive inputs with random output backpressure.
    n0 = n_out5;
    for (int v = 0; v < 32; v++) begin
      int b;
      in_valid5 = 1'b1;
      in_data5  = 5'(v);
      b = 0;
      ok = 1'b0;
      while (!ok && b < 50) begin
        out_ready5 = 1'($urandom_range(0, 1));
        #1;
        ok = in_ready5;
        step();
        b++;
      end
      if (!ok) cmp("w5_accept_timeout", 32'(v), 32'hFFFF_FFFF);
    end
    in_valid5 = 1'b0;
    out_ready5 = 1'b1;
    drain5();
    cmp("w5_output_count", n_out5 - n0, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
